// File: rtl/if_fetch_ctrl_pkg.sv
// if_fetch_ctrl_pkg: shared constants and state encoding for the IF fetch controller
package if_fetch_ctrl_pkg;
  localparam logic RSTN_ENABLE = 1'b0;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam int INST_BYTES = 8;
  typedef enum logic [1:0] {S_RST, S_RUN, S_DBG} if_state_e;
endpackage

// File: rtl/if_fetch_ctrl_fetch_buf.sv
// if_fetch_ctrl_fetch_buf: 2-entry {pc,inst} FIFO with flush; head is always slot 0
module if_fetch_ctrl_fetch_buf
  import if_fetch_ctrl_pkg::*;
#(
  parameter int AW = 32,
  parameter int IW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [AW-1:0] push_pc,
  input  logic [IW-1:0] push_inst,
  output logic [1:0]    count,
  output logic [AW-1:0] head_pc,
  output logic [IW-1:0] head_inst
);
  logic [AW-1:0] pc_q [2];
  logic [IW-1:0] inst_q [2];
  logic do_push, do_pop, wi;
  assign do_push = push && count != 2'd2;
  assign do_pop = pop && count != 2'd0;
  assign wi = count[0] & ~do_pop;
  assign head_pc = pc_q[0];
  assign head_inst = inst_q[0];
  always_ff @(posedge clk or negedge rst)
    if (rst == RSTN_ENABLE) begin
      count <= 2'd0;
      pc_q <= '{default: '0};
      inst_q <= '{default: '0};
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      if (do_pop) begin
        pc_q[0] <= pc_q[1];
        inst_q[0] <= inst_q[1];
      end
      // a push lands in the slot that is free after this cycle's pop
      if (do_push) begin
        pc_q[wi] <= push_pc;
        inst_q[wi] <= push_inst;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: ROM fetch sequencer with branch redirect, 2-entry buffer and shared debug read port
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              halt,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [INST_W-1:0] dbg_rdata
);
  if_state_e state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [1:0] count;
  logic dbg_turn, active, br, fetch_ok, dbg_grant, fetch;
  always_ff @(posedge clk or negedge rst)
    if (rst == RSTN_ENABLE) state <= S_RST;
    else state <= state_nxt;
  always_comb begin
    state_nxt = S_RUN;
    if (state == S_RUN && dbg_grant) state_nxt = S_DBG;
  end
  always_comb begin
    active = state != S_RST;
    rom_ce = active ? CHIP_ENABLE : CHIP_DISABLE;
    dbg_ack = state == S_DBG;
    br = active && br_valid;
    // eligibility sees only registered count, keeping if_ready off the ROM address path
    fetch_ok = active && !halt && count != 2'd2;
    dbg_grant = state == S_RUN && !br_valid && dbg_req && (dbg_turn || !fetch_ok);
    fetch = fetch_ok && !br && !dbg_grant;
    rom_addr = dbg_grant ? dbg_addr : pc;
    if_valid = count != 2'd0;
  end
  always_ff @(posedge clk or negedge rst)
    if (rst == RSTN_ENABLE) begin
      pc <= RESET_PC;
      dbg_turn <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      pc <= br ? br_target & ~ADDR_W'(INST_BYTES - 1) : fetch ? pc + ADDR_W'(INST_BYTES) : pc;
      dbg_turn <= dbg_grant ? 1'b0 : fetch ? 1'b1 : dbg_turn;
      if (dbg_grant) dbg_rdata <= rom_inst;
    end
  if_fetch_ctrl_fetch_buf #(.AW(ADDR_W), .IW(INST_W)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (fetch),
    .pop      (if_ready && if_valid),
    .flush    (br),
    .push_pc  (pc),
    .push_inst(rom_inst),
    .count    (count),
    .head_pc  (if_pc),
    .head_inst(if_inst)
  );
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed cycle table plus reset/wrap sequences for if_fetch_ctrl
module tb_if_fetch_ctrl;
  logic clk, rst;
  logic rom_ce, if_valid, if_ready, halt, br_valid, dbg_req, dbg_ack;
  logic [31:0] rom_addr, br_target, if_pc, dbg_addr;
  logic [63:0] rom_inst, if_inst, dbg_rdata;
  logic rom_ce2, if_valid2, dbg_ack2;
  logic [31:0] rom_addr2, if_pc2;
  logic [63:0] rom_inst2, if_inst2, dbg_rdata2;
  int passed = 0, total = 0;

  function automatic logic [63:0] rom_word(input logic [31:0] a);
    return {a ^ 32'h5A5A_0000, ~a};
  endfunction

  assign rom_inst = rom_word(rom_addr);
  assign rom_inst2 = rom_word(rom_addr2);

  if_fetch_ctrl dut (
    .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .halt(halt), .br_valid(br_valid), .br_target(br_target), .if_valid(if_valid),
    .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst), .dbg_req(dbg_req),
    .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata)
  );

  if_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF0)) dut_wrap (
    .clk(clk), .rst(rst), .rom_ce(rom_ce2), .rom_addr(rom_addr2), .rom_inst(rom_inst2),
    .halt(1'b0), .br_valid(1'b0), .br_target(32'h0), .if_valid(if_valid2),
    .if_ready(1'b1), .if_pc(if_pc2), .if_inst(if_inst2), .dbg_req(1'b0),
    .dbg_addr(32'h0), .dbg_ack(dbg_ack2), .dbg_rdata(dbg_rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  typedef struct {
    logic rdy, hlt, br;
    logic [31:0] bt;
    logic dreq;
    logic [31:0] daddr;
    logic ce, v;
    logic [31:0] pc, addr;
    logic ack;
    logic [31:0] raddr;
  } vec_t;

  localparam int NV = 27;
  vec_t vec [NV];
  logic [31:0] wrap_pc [3];

  initial begin
    //          rdy hlt br bt      dreq daddr    ce v  pc        addr      ack raddr
    vec[0]  = '{1, 0, 0, 32'h00, 0, 32'h00, 0, 0, 32'h00, 32'h00, 0, 32'h00};
    vec[1]  = '{1, 0, 0, 32'h00, 0, 32'h00, 1, 0, 32'h00, 32'h00, 0, 32'h00};
    vec[2]  = '{0, 0, 0, 32'h00, 0, 32'h00, 1, 1, 32'h00, 32'h08, 0, 32'h00};
    vec[3]  = '{0, 0, 0, 32'h00, 0, 32'h00, 1, 1, 32'h00, 32'h10, 0, 32'h00};
    vec[4]  = '{0, 0, 0, 32'h00, 0, 32'h00, 1, 1, 32'h00, 32'h10, 0, 32'h00};
    vec[5]  = '{0, 0, 0, 32'h00, 0, 32'h00, 1, 1, 32'h00, 32'h10, 0, 32'h00};
    vec[6]  = '{0, 0, 0, 32'h00, 0, 32'h00, 1, 1, 32'h00, 32'h10, 0, 32'h00};
    vec[7]  = '{1, 0, 0, 32'h00, 0, 32'h00, 1, 1, 32'h00, 32'h10, 0, 32'h00};
    vec[8]  = '{1, 0, 0, 32'h00, 0, 32'h00, 1, 1, 32'h08, 32'h10, 0, 32'h00};
    vec[9]  = '{1, 0, 0, 32'h00, 0, 32'h00, 1, 1, 32'h10, 32'h18, 0, 32'h00};
    vec[10] = '{0, 0, 0, 32'h00, 0, 32'h00, 1, 1, 32'h18, 32'h20, 0, 32'h00};
    vec[11] = '{0, 0, 1, 32'h2B, 0, 32'h00, 1, 1, 32'h18, 32'h28, 0, 32'h00};
    vec[12] = '{1, 0, 0, 32'h00, 0, 32'h00, 1, 0, 32'h00, 32'h28, 0, 32'h00};
    vec[13] = '{1, 0, 0, 32'h00, 0, 32'h00, 1, 1, 32'h28, 32'h30, 0, 32'h00};
    vec[14] = '{1, 0, 0, 32'h00, 1, 32'h10, 1, 1, 32'h30, 32'h10, 0, 32'h00};
    vec[15] = '{1, 0, 0, 32'h00, 1, 32'h10, 1, 0, 32'h00, 32'h38, 1, 32'h10};
    vec[16] = '{1, 0, 0, 32'h00, 1, 32'h18, 1, 1, 32'h38, 32'h18, 0, 32'h00};
    vec[17] = '{1, 0, 0, 32'h00, 1, 32'h18, 1, 0, 32'h00, 32'h40, 1, 32'h18};
    vec[18] = '{1, 0, 0, 32'h00, 0, 32'h00, 1, 1, 32'h40, 32'h48, 0, 32'h00};
    vec[19] = '{1, 0, 1, 32'h00, 1, 32'h08, 1, 1, 32'h48, 32'h50, 0, 32'h00};
    vec[20] = '{1, 0, 0, 32'h00, 1, 32'h08, 1, 0, 32'h00, 32'h08, 0, 32'h00};
    vec[21] = '{1, 0, 0, 32'h00, 1, 32'h08, 1, 0, 32'h00, 32'h00, 1, 32'h08};
    vec[22] = '{1, 0, 0, 32'h00, 0, 32'h00, 1, 1, 32'h00, 32'h08, 0, 32'h00};
    vec[23] = '{1, 1, 0, 32'h00, 0, 32'h00, 1, 1, 32'h08, 32'h10, 0, 32'h00};
    vec[24] = '{1, 1, 1, 32'h40, 0, 32'h00, 1, 0, 32'h00, 32'h10, 0, 32'h00};
    vec[25] = '{1, 0, 0, 32'h00, 0, 32'h00, 1, 0, 32'h00, 32'h40, 0, 32'h00};
    vec[26] = '{1, 0, 0, 32'h00, 0, 32'h00, 1, 1, 32'h40, 32'h48, 0, 32'h00};
    wrap_pc = '{32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'h0000_0000};

    rst = 1'b0; if_ready = 1'b0; halt = 1'b0; br_valid = 1'b0;
    br_target = '0; dbg_req = 1'b0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst rom_ce", rom_ce, 0);
    chk("rst if_valid", if_valid, 0);
    chk("rst if_pc", if_pc, 0);
    chk("rst if_inst", if_inst, 0);
    chk("rst dbg_ack", dbg_ack, 0);
    chk("rst dbg_rdata", dbg_rdata, 0);
    chk("rst wrap rom_addr", rom_addr2, 64'hFFFF_FFF0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if_ready = vec[i].rdy; halt = vec[i].hlt; br_valid = vec[i].br;
      br_target = vec[i].bt; dbg_req = vec[i].dreq; dbg_addr = vec[i].daddr;
      #1;
      chk($sformatf("c%0d rom_ce", i), rom_ce, vec[i].ce);
      chk($sformatf("c%0d if_valid", i), if_valid, vec[i].v);
      if (vec[i].v) begin
        chk($sformatf("c%0d if_pc", i), if_pc, vec[i].pc);
        chk($sformatf("c%0d if_inst", i), if_inst, rom_word(vec[i].pc));
      end
      chk($sformatf("c%0d rom_addr", i), rom_addr, vec[i].addr);
      chk($sformatf("c%0d dbg_ack", i), dbg_ack, vec[i].ack);
      if (vec[i].ack) chk($sformatf("c%0d dbg_rdata", i), dbg_rdata, rom_word(vec[i].raddr));
      if (i >= 2 && i <= 4) begin
        chk($sformatf("c%0d wrap if_valid", i), if_valid2, 1);
        chk($sformatf("c%0d wrap if_pc", i), if_pc2, wrap_pc[i-2]);
        chk($sformatf("c%0d wrap if_inst", i), if_inst2, rom_word(wrap_pc[i-2]));
      end
      @(negedge clk);
    end

    // reset lands while a debug read is being granted
    if_ready = 1'b1; halt = 1'b0; br_valid = 1'b0; dbg_req = 1'b1; dbg_addr = 32'h10;
    #1;
    chk("mid grant rom_addr", rom_addr, 32'h10);
    #2;
    rst = 1'b0;
    #1;
    chk("mid rst rom_ce", rom_ce, 0);
    chk("mid rst rom_addr", rom_addr, 0);
    chk("mid rst if_valid", if_valid, 0);
    chk("mid rst if_pc", if_pc, 0);
    chk("mid rst dbg_ack", dbg_ack, 0);
    chk("mid rst dbg_rdata", dbg_rdata, 0);
    repeat (2) @(negedge clk);
    dbg_req = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("post rst %0d dbg_ack", i), dbg_ack, 0);
      @(negedge clk);
    end
    chk("post rst dbg_rdata", dbg_rdata, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
